// File: rtl/instr_fetch_unit.sv
// Fetch stage: holds the PC, fetches words over a ready handshake, presents each
// instruction until acknowledged, then advances sequentially or to a redirect target.
module instr_fetch_unit #(
  parameter int unsigned     XLEN           = 32,
  parameter logic [XLEN-1:0] RESET_PC       = '0,
  parameter int unsigned     TIMEOUT_CYCLES = 16
) (
  input  logic            i_clk,
  input  logic            i_reset,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_ready,
  input  logic [31:0]     i_imem_rdata,
  output logic [31:0]     o_instr,
  output logic            o_instr_valid,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_pc_plus4,
  input  logic            i_instr_ack,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_target,
  output logic            o_fetch_err,
  output logic [1:0]      o_err_code
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [31:0] NOP   = 32'h0000_0013;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD, S_ERROR} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [XLEN-1:0]  r_pc;
  logic [XLEN-1:0]  w_pc_nxt;
  logic [31:0]      r_instr;
  logic [31:0]      w_instr_nxt;
  logic             r_instr_valid;
  logic             w_instr_valid_nxt;
  logic [1:0]       r_err_code;
  logic [1:0]       w_err_code_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [XLEN-1:0]  w_pc_plus4;
  logic [XLEN-1:0]  w_target;
  logic [XLEN-1:0]  w_branch_pc;

  assign w_pc_plus4  = r_pc + XLEN'(4);
  assign w_target    = i_redirect_target & ~XLEN'(1);
  assign w_branch_pc = i_redirect ? w_target : w_pc_plus4;

  // State and datapath registers
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_PC;
      r_instr       <= NOP;
      r_instr_valid <= 1'b0;
      r_err_code    <= ERR_NONE;
      r_cnt         <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_instr       <= w_instr_nxt;
      r_instr_valid <= w_instr_valid_nxt;
      r_err_code    <= w_err_code_nxt;
      r_cnt         <= w_cnt_nxt;
    end
  end

  // Next-state and datapath update
  always_comb begin
    w_state_nxt       = r_state;
    w_pc_nxt          = r_pc;
    w_instr_nxt       = r_instr;
    w_instr_valid_nxt = r_instr_valid;
    w_err_code_nxt    = r_err_code;
    w_cnt_nxt         = r_cnt;
    case (r_state)
      S_IDLE: w_state_nxt = S_FETCH;
      S_FETCH: begin
        // Ready takes priority over an expiring timeout in the same cycle
        if (i_imem_ready) begin
          w_instr_nxt       = i_imem_rdata;
          w_instr_valid_nxt = 1'b1;
          w_cnt_nxt         = '0;
          w_state_nxt       = S_HOLD;
        end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          w_err_code_nxt = ERR_TIMEOUT;
          w_state_nxt    = S_ERROR;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (i_instr_ack) begin
          w_instr_valid_nxt = 1'b0;
          w_pc_nxt          = w_branch_pc;
          if (w_branch_pc[1]) begin
            w_err_code_nxt = ERR_MISALIGN;
            w_state_nxt    = S_ERROR;
          end else begin
            w_state_nxt = S_FETCH;
          end
        end
      end
      S_ERROR: w_state_nxt = S_ERROR;
      default: w_state_nxt = S_ERROR;
    endcase
  end

  // Moore outputs decoded from the state register
  always_comb begin
    o_imem_req  = 1'b0;
    o_fetch_err = 1'b0;
    case (r_state)
      S_FETCH: o_imem_req  = 1'b1;
      S_ERROR: o_fetch_err = 1'b1;
      default: ;
    endcase
  end

  assign o_imem_addr   = r_pc;
  assign o_pc          = r_pc;
  assign o_pc_plus4    = w_pc_plus4;
  assign o_instr       = r_instr;
  assign o_instr_valid = r_instr_valid;
  assign o_err_code    = r_err_code;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: drivers queue expected fetches/errors,
// a negedge monitor checks them as instr_valid / fetch_err rise.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        instr_ack;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        fetch_err;
  logic [1:0]  err_code;

  int n_vec = 0;
  int n_mis = 0;
  logic [63:0] q_fetch[$];
  logic [63:0] q_err[$];
  logic prev_v = 1'b0;
  logic prev_e = 1'b0;

  instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .TIMEOUT_CYCLES(4)) dut (
    .i_clk(clk), .i_reset(rst),
    .o_imem_req(imem_req), .o_imem_addr(imem_addr),
    .i_imem_ready(imem_ready), .i_imem_rdata(imem_rdata),
    .o_instr(instr), .o_instr_valid(instr_valid),
    .o_pc(pc), .o_pc_plus4(pc_plus4),
    .i_instr_ack(instr_ack), .i_redirect(redirect), .i_redirect_target(redirect_target),
    .o_fetch_err(fetch_err), .o_err_code(err_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: pop expected {instr,pc} on valid rise and {code,pc} on error rise
  always @(negedge clk) begin
    if (instr_valid && !prev_v) begin
      if (q_fetch.size() == 0) begin
        n_vec++; n_mis++;
        $display("FAIL fetch_unexpected: got instr %h pc %h, expected no fetch", instr, pc);
      end else chk("fetch", {instr, pc}, q_fetch.pop_front());
    end
    if (fetch_err && !prev_e) begin
      if (q_err.size() == 0) begin
        n_vec++; n_mis++;
        $display("FAIL err_unexpected: got code %b pc %h, expected no error", err_code, pc);
      end else chk("error", {30'h0, err_code, pc}, q_err.pop_front());
    end
    prev_v = instr_valid;
    prev_e = fetch_err;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] addr, input logic [31:0] data,
                       input int waits, input logic stray);
    int n = 0;
    while (!imem_req && n < 20) begin tick(); n++; end
    chk("req_seen", 64'(imem_req), 64'd1);
    chk("imem_addr", 64'(imem_addr), 64'(addr));
    instr_ack = stray; redirect = stray; redirect_target = 32'h22;
    repeat (waits) tick();
    instr_ack = 1'b0; redirect = 1'b0;
    imem_rdata = data; imem_ready = 1'b1;
    q_fetch.push_back({data, addr});
    tick();
    imem_ready = 1'b0; imem_rdata = 32'hBAD0_BAD0;
  endtask

  task automatic ack(input logic redir, input logic [31:0] target);
    int n = 0;
    while (!instr_valid && n < 20) begin tick(); n++; end
    chk("valid_seen", 64'(instr_valid), 64'd1);
    instr_ack = 1'b1; redirect = redir; redirect_target = target;
    tick();
    instr_ack = 1'b0; redirect = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] tab [4];
    tab[0] = 32'h0000_0093; tab[1] = 32'h0010_0113;
    tab[2] = 32'h0020_0193; tab[3] = 32'h0030_0213;
    rst = 1'b1; imem_ready = 1'b0; imem_rdata = 32'h0; instr_ack = 1'b0;
    redirect = 1'b0; redirect_target = 32'h0;
    repeat (3) tick();
    chk("rst_pc", 64'(pc), 64'h0);
    chk("rst_instr_nop", 64'(instr), 64'h13);
    chk("rst_valid", 64'(instr_valid), 64'h0);
    chk("rst_req", 64'(imem_req), 64'h0);
    chk("rst_err", {61'h0, fetch_err, err_code}, 64'h0);
    chk("rst_pc_plus4", 64'(pc_plus4), 64'h4);
    rst = 1'b0;

    // Sequential fetch with immediate ready/ack: 2 cycles per instruction
    for (int i = 0; i < 4; i++) begin
      fetch(32'(4 * i), tab[i], 0, 1'b0);
      ack(1'b0, 32'h0);
      chk("seq_req_next", 64'(imem_req), 64'h1);
      chk("seq_valid_low", 64'(instr_valid), 64'h0);
    end
    fetch(32'h10, 32'h00A0_0093, 0, 1'b0);

    // Long HOLD with a stray ready: nothing moves
    imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_pc", 64'(pc), 64'h10);
      chk("hold_instr", 64'(instr), 64'h00A0_0093);
      chk("hold_valid", 64'(instr_valid), 64'h1);
      chk("hold_req", 64'(imem_req), 64'h0);
    end
    imem_ready = 1'b0;

    // Redirect clears bit0; stray ack during FETCH ignored
    ack(1'b1, 32'h41);
    chk("redir_noerr", 64'(fetch_err), 64'h0);
    fetch(32'h40, 32'h1234_5067, 2, 1'b1);
    ack(1'b0, 32'h0);
    // Ready on the last allowed FETCH cycle wins over timeout
    fetch(32'h44, 32'h0040_006F, 3, 1'b0);
    ack(1'b1, 32'hFFFF_FFFC);
    fetch(32'hFFFF_FFFC, 32'h0000_0067, 0, 1'b0);
    chk("wrap_pc_plus4", 64'(pc_plus4), 64'h0);
    ack(1'b0, 32'h0);
    chk("wrap_noerr", 64'(fetch_err), 64'h0);
    fetch(32'h0, 32'h0050_0293, 0, 1'b0);

    // Misaligned redirect traps and freezes
    q_err.push_back({30'h0, 2'b01, 32'h22});
    ack(1'b1, 32'h22);
    imem_ready = 1'b1; instr_ack = 1'b1; redirect = 1'b1; redirect_target = 32'h80;
    for (int i = 0; i < 5; i++) begin
      chk("err_req", 64'(imem_req), 64'h0);
      chk("err_state", {29'h0, instr_valid, fetch_err, err_code, pc}, {29'h0, 1'b0, 1'b1, 2'b01, 32'h22});
      tick();
    end
    imem_ready = 1'b0; instr_ack = 1'b0; redirect = 1'b0;

    // Asynchronous reset out of ERROR
    rst = 1'b1;
    #1;
    chk("arst_clear", {29'h0, instr_valid, fetch_err, err_code, pc}, 64'h0);
    chk("arst_instr", 64'(instr), 64'h13);
    tick();
    rst = 1'b0;
    tick();
    chk("mid_fetch_req", 64'(imem_req), 64'h1);
    // Reset mid-FETCH with late ready: data must not be captured
    rst = 1'b1;
    #1;
    imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    tick();
    rst = 1'b0;
    tick();
    imem_ready = 1'b0;
    chk("late_instr", 64'(instr), 64'h13);
    chk("late_valid", 64'(instr_valid), 64'h0);
    chk("late_req", {31'h0, imem_req, pc}, {31'h0, 1'b1, 32'h0});

    // Timeout after exactly 4 FETCH cycles
    repeat (3) tick();
    chk("to_pre_req", 64'(imem_req), 64'h1);
    chk("to_pre_err", 64'(fetch_err), 64'h0);
    q_err.push_back({30'h0, 2'b10, 32'h0});
    tick();
    chk("to_err", {62'h0, err_code}, 64'h2);
    chk("to_req", 64'(imem_req), 64'h0);
    tick();

    chk("fetch_q_empty", 64'(q_fetch.size()), 64'h0);
    chk("err_q_empty", 64'(q_err.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
